// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings,
// FSM state type and small op-classification helpers.
package mdu_pkg;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mduStateT;

    // Ops that need the iterative core and therefore stall EX.
    function automatic logic is_long_op(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) ||
               (op == OP_DIV)  || (op == OP_DIVU);
    endfunction

    // Ops whose operands are two's-complement and need magnitude/sign fixing.
    function automatic logic isSignedOp(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    // Ops that run the core in restoring-divide mode.
    function automatic logic isDivOp(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// Iterative datapath for the MDU: a 2*WIDTH shift register with one
// adder/subtractor, performing one shift-add multiply step or one
// restoring shift-subtract divide step per enabled cycle.
module mdu_iter_core
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic               divMode,
    input  logic [WIDTH-1:0]   loadA,
    input  logic [WIDTH-1:0]   operandB,
    output logic [2*WIDTH-1:0] acc
);

    logic [WIDTH-1:0] upper;
    logic [WIDTH-1:0] lower;
    logic [WIDTH:0]   mulSum;
    logic [WIDTH:0]   divShifted;
    logic [WIDTH:0]   divTrial;

    // Single adder/subtractor shared conceptually by both modes. In multiply
    // mode the carry bit is kept so the right shift does not lose it. In
    // divide mode the partial remainder is widened by one bit so that bit
    // WIDTH of the difference acts as the borrow (remainder < divisor).
    always_comb begin
        mulSum     = {1'b0, upper} + (lower[0] ? {1'b0, operandB} : {(WIDTH+1){1'b0}});
        divShifted = {upper, lower[WIDTH-1]};
        divTrial   = divShifted - {1'b0, operandB};
    end

    // Upper half holds the partial product / partial remainder, lower half
    // holds the multiplier bits still to consume / the quotient being built.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upper <= '0;
            lower <= '0;
        end else if (load) begin
            upper <= '0;
            lower <= loadA;
        end else if (step) begin
            if (divMode) begin
                if (!divTrial[WIDTH]) begin
                    upper <= divTrial[WIDTH-1:0];
                    lower <= {lower[WIDTH-2:0], 1'b1};
                end else begin
                    upper <= divShifted[WIDTH-1:0];
                    lower <= {lower[WIDTH-2:0], 1'b0};
                end
            end else begin
                upper <= mulSum[WIDTH:1];
                lower <= {mulSum[0], lower[WIDTH-1:1]};
            end
        end
    end

    assign acc = {upper, lower};

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit for the EX stage. Owns HI/LO, sequences the
// iterative core through WIDTH steps for MULT/MULTU/DIV/DIVU, stalls EX via
// MDUReadyE and serves MTHI/MTLO/MFHI/MFLO in a single cycle.
module mdu
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       MDUOpE,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    output logic             MDUReadyE,
    output logic [WIDTH-1:0] HiLoOutE
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    mduStateT           state;
    logic [CNT_W-1:0]   counter;
    logic [3:0]         opReg;
    logic [WIDTH-1:0]   aRaw;
    logic [WIDTH-1:0]   bReg;
    logic               negResult;
    logic               negRem;
    logic               divZero;
    logic [WIDTH-1:0]   hiReg;
    logic [WIDTH-1:0]   loReg;

    logic               startSigned;
    logic [WIDTH-1:0]   srcAMag;
    logic [WIDTH-1:0]   srcBMag;
    logic               startLong;
    logic               startDivZero;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   resHi;
    logic [WIDTH-1:0]   resLo;

    // Operand conditioning at issue: signed ops run on magnitudes, and a
    // zero divisor is detected up front so the core is skipped entirely.
    always_comb begin
        startSigned  = isSignedOp(MDUOpE);
        startLong    = (state == IDLE) && is_long_op(MDUOpE);
        startDivZero = isDivOp(MDUOpE) && (SrcBE == '0);
        srcAMag      = (startSigned && SrcAE[WIDTH-1]) ? -SrcAE : SrcAE;
        srcBMag      = (startSigned && SrcBE[WIDTH-1]) ? -SrcBE : SrcBE;
    end

    mdu_iter_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (startLong),
        .step    (state == BUSY),
        .divMode (isDivOp(opReg)),
        .loadA   (srcAMag),
        .operandB(bReg),
        .acc     (acc)
    );

    // Sign fix-up of the unsigned core result. 0x80000000 / -1 needs no
    // special case: the magnitude quotient 0x80000000 negates to itself.
    always_comb begin
        product = negResult ? -acc : acc;
        quot    = acc[WIDTH-1:0];
        rem     = acc[2*WIDTH-1:WIDTH];
        resHi   = product[2*WIDTH-1:WIDTH];
        resLo   = product[WIDTH-1:0];
        if (isDivOp(opReg)) begin
            if (divZero) begin
                resLo = '1;
                resHi = aRaw;
            end else begin
                resLo = negResult ? -quot : quot;
                resHi = negRem ? -rem : rem;
            end
        end
    end

    // Control FSM: latches operands at issue, counts WIDTH core steps,
    // and commits HI/LO on the DONE edge as the stalled instruction leaves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            counter   <= '0;
            opReg     <= OP_NOP;
            aRaw      <= '0;
            bReg      <= '0;
            negResult <= 1'b0;
            negRem    <= 1'b0;
            divZero   <= 1'b0;
            hiReg     <= '0;
            loReg     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (is_long_op(MDUOpE)) begin
                        opReg     <= MDUOpE;
                        aRaw      <= SrcAE;
                        bReg      <= srcBMag;
                        negResult <= startSigned && (SrcAE[WIDTH-1] ^ SrcBE[WIDTH-1]);
                        negRem    <= startSigned && SrcAE[WIDTH-1];
                        divZero   <= startDivZero;
                        counter   <= CNT_LAST;
                        state     <= startDivZero ? DONE : BUSY;
                    end else if (MDUOpE == OP_MTHI) begin
                        hiReg <= SrcAE;
                    end else if (MDUOpE == OP_MTLO) begin
                        loReg <= SrcAE;
                    end
                end
                BUSY: begin
                    if (counter == '0) begin
                        state <= DONE;
                    end else begin
                        counter <= counter - CNT_W'(1);
                    end
                end
                DONE: begin
                    hiReg <= resHi;
                    loReg <= resLo;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Stall request to the hazard unit; only the op code feeds it in IDLE.
    always_comb begin
        MDUReadyE = 1'b1;
        if (rst_n) begin
            unique case (state)
                IDLE:    MDUReadyE = !is_long_op(MDUOpE);
                BUSY:    MDUReadyE = 1'b0;
                default: MDUReadyE = 1'b1;
            endcase
        end
    end

    // Move-from-HI/LO read port straight off the architectural registers.
    always_comb begin
        HiLoOutE = '0;
        if (MDUOpE == OP_MFHI) begin
            HiLoOutE = hiReg;
        end else if (MDUOpE == OP_MFLO) begin
            HiLoOutE = loReg;
        end
    end

endmodule
